// File: rtl/cga_fetch_pkg.sv
// Shared definitions for the CGA scanline fetcher: SRAM address width,
// maximum CGA line length and the fetch state encoding.
package cga_fetch_pkg;

    localparam int SRAM_AW     = 19;
    localparam int CGA_MAX_LEN = 80;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/cga_fetch_if.sv
// CGA side of the SRAM arbiter: read request/address out, read data in,
// plus the higher-priority busy indication.
interface cga_fetch_if;

    logic                               enacga;
    logic [cga_fetch_pkg::SRAM_AW-1:0]  addracga;
    logic [7:0]                         doutacga;
    logic                               hp_busy;

    modport master (
        output enacga,
        output addracga,
        input  doutacga,
        input  hp_busy
    );

    modport slave (
        input  enacga,
        input  addracga,
        output doutacga,
        output hp_busy
    );

endinterface

// File: rtl/cga_fifo.sv
// Byte FIFO with first-word fall-through head and an occupancy count.
// Pushes when full and pops when empty are dropped.
module cga_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clka,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count_reg != (AW+1)'(DEPTH));
    assign do_pop  = pop && (count_reg != '0);

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clka) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    assign head  = mem[rd_ptr_reg];
    assign valid = (count_reg != '0);
    assign count = count_reg;

endmodule

// File: rtl/cga_fetch.sv
// CGA scanline fetcher: issues SRAM byte reads for one line into a small
// FIFO, throttled so buffered plus in-flight bytes never exceed its depth.
module cga_fetch
    import cga_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 7
) (
    input  logic               clka,
    input  logic               reset,
    input  logic               line_start,
    input  logic [SRAM_AW-1:0] line_base,
    input  logic [LEN_W-1:0]   line_len,
    cga_fetch_if.master        sram,
    input  logic               pop,
    output logic [7:0]         pix_data,
    output logic               pix_valid,
    output logic               busy,
    output logic               underrun
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t       state_reg;
    fetch_state_t       state_next;
    logic [SRAM_AW-1:0] addr_reg;
    logic [LEN_W-1:0]   remaining_reg;
    logic [1:0]         vpipe_reg;
    logic               underrun_reg;

    logic [CW-1:0]      fifo_count;
    logic [CW:0]        occupancy;
    logic               start;
    logic               req;
    logic               served;

    assign start     = line_start && (state_reg == ST_IDLE);
    assign occupancy = (CW+1)'(fifo_count) + (CW+1)'(vpipe_reg[0]) + (CW+1)'(vpipe_reg[1]);
    assign req       = (state_reg == ST_FETCH) && (remaining_reg != '0)
                       && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign served    = req && !sram.hp_busy;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_FETCH;
            ST_FETCH: if ((remaining_reg == '0) || (served && (remaining_reg == LEN_W'(1))))
                          state_next = ST_DRAIN;
            // Leave as the final in-flight byte lands, so busy falls with that push.
            ST_DRAIN: if (!vpipe_reg[0]) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            vpipe_reg     <= '0;
            underrun_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            vpipe_reg <= {vpipe_reg[0], served};
            if (start) begin
                addr_reg      <= line_base;
                remaining_reg <= line_len;
            end else if (served) begin
                addr_reg      <= addr_reg + 1'b1;
                remaining_reg <= remaining_reg - 1'b1;
            end
            if (pop && !pix_valid) underrun_reg <= 1'b1;
        end
    end

    cga_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clka      (clka),
        .reset     (reset),
        .push      (vpipe_reg[1]),
        .push_data (sram.doutacga),
        .pop       (pop),
        .head      (pix_data),
        .valid     (pix_valid),
        .count     (fifo_count)
    );

    assign sram.enacga   = req;
    assign sram.addracga = addr_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign underrun      = underrun_reg;

endmodule
